// File: rtl/axi4_sub_pkg.sv
// Shared types and constants for the AXI4 memory-backed subordinate.
package axi4_sub_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    B_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_bus_if.sv
// AXI4 bus bundle with manager and subordinate views.
interface axi4_bus_if #(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 64,
  parameter int AXI4_ID_WIDTH   = 4,
  parameter int AXI4_USER_WIDTH = 1
) ();
  localparam int STRB_W = AXI4_DATA_WIDTH / 8;

  logic [AXI4_ID_WIDTH-1:0]   aw_id;
  logic [AXI4_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                 aw_len;
  logic [2:0]                 aw_size;
  logic [1:0]                 aw_burst;
  logic                       aw_lock;
  logic [3:0]                 aw_cache;
  logic [2:0]                 aw_prot;
  logic [3:0]                 aw_qos;
  logic [3:0]                 aw_region;
  logic [5:0]                 aw_atop;
  logic [AXI4_USER_WIDTH-1:0] aw_user;
  logic                       aw_valid;
  logic                       aw_ready;

  logic [AXI4_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]          w_strb;
  logic                       w_last;
  logic [AXI4_USER_WIDTH-1:0] w_user;
  logic                       w_valid;
  logic                       w_ready;

  logic [AXI4_ID_WIDTH-1:0]   b_id;
  logic [1:0]                 b_resp;
  logic [AXI4_USER_WIDTH-1:0] b_user;
  logic                       b_valid;
  logic                       b_ready;

  logic [AXI4_ID_WIDTH-1:0]   ar_id;
  logic [AXI4_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                 ar_len;
  logic [2:0]                 ar_size;
  logic [1:0]                 ar_burst;
  logic                       ar_lock;
  logic [3:0]                 ar_cache;
  logic [2:0]                 ar_prot;
  logic [3:0]                 ar_qos;
  logic [3:0]                 ar_region;
  logic [AXI4_USER_WIDTH-1:0] ar_user;
  logic                       ar_valid;
  logic                       ar_ready;

  logic [AXI4_ID_WIDTH-1:0]   r_id;
  logic [AXI4_DATA_WIDTH-1:0] r_data;
  logic [1:0]                 r_resp;
  logic                       r_last;
  logic [AXI4_USER_WIDTH-1:0] r_user;
  logic                       r_valid;
  logic                       r_ready;

  modport Manager (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Subordinate (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi4_sub_addr_gen.sv
// Burst address walker: latches AX fields, tracks word address and beat count,
// and flags out-of-range beats and unsupported burst/size encodings.
module axi4_sub_addr_gen
  import axi4_sub_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 64,
  parameter int                 MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  localparam int                IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_len,
  input  logic [1:0]        i_burst,
  input  logic [2:0]        i_size,
  input  logic              i_advance,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_in_range,
  output logic              o_last,
  output logic              o_bad
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int WA_W  = ADDR_W - OFF_W;
  localparam logic [WA_W-1:0] BASE_W  = BASE_ADDR[ADDR_W-1:OFF_W];
  localparam logic [WA_W-1:0] DEPTH_W = WA_W'(MEM_DEPTH);

  logic [WA_W-1:0] r_waddr;
  logic [7:0]      r_len;
  logic [7:0]      r_cnt;
  logic [1:0]      r_burst;
  logic            r_bad;
  logic [WA_W-1:0] w_off;

  // Latch the burst on accept, then step the beat counter (and the word
  // address for INCR) on every beat handshake; word address wraps freely.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_waddr <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= BURST_FIXED;
      r_bad   <= 1'b0;
    end else if (i_load) begin
      r_waddr <= WA_W'(i_addr >> OFF_W);
      r_len   <= i_len;
      r_cnt   <= '0;
      r_burst <= i_burst;
      r_bad   <= ((i_burst != BURST_FIXED) && (i_burst != BURST_INCR)) ||
                 (i_size != 3'(OFF_W));
    end else if (i_advance) begin
      r_cnt <= r_cnt + 8'd1;
      if (r_burst == BURST_INCR) r_waddr <= r_waddr + 1'b1;
    end
  end

  assign w_off      = r_waddr - BASE_W;
  assign o_in_range = (r_waddr >= BASE_W) && (w_off < DEPTH_W);
  assign o_idx      = w_off[IDX_W-1:0];
  assign o_last     = (r_cnt == r_len);
  assign o_bad      = r_bad;

endmodule

// File: rtl/axi4_sub_mem.sv
// AXI4 subordinate backed by a word array; independent single-outstanding
// read and write engines, FIXED/INCR bursts, SLVERR on bad bursts or range.
module axi4_sub_mem
  import axi4_sub_pkg::*;
#(
  parameter int                          AXI4_ADDR_WIDTH = 32,
  parameter int                          AXI4_DATA_WIDTH = 64,
  parameter int                          AXI4_ID_WIDTH   = 4,
  parameter int                          MEM_DEPTH       = 256,
  parameter logic [AXI4_ADDR_WIDTH-1:0]  BASE_ADDR       = '0
) (
  input logic             clk_i,
  input logic             rstn_i,
  axi4_bus_if.Subordinate axi_sub_if
);
  localparam int STRB_W = AXI4_DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  wr_state_t                  r_wst;
  rd_state_t                  r_rst;
  logic [AXI4_ID_WIDTH-1:0]   r_bid;
  logic [AXI4_ID_WIDTH-1:0]   r_rid;
  logic                       r_berr;
  logic [AXI4_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic             w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
  logic [IDX_W-1:0] w_widx, w_ridx;
  logic             w_win, w_wlast, w_wbad, w_wok;
  logic             w_rin, w_rlast, w_rbad, w_rok;

  assign w_aw_hs = (r_wst == W_IDLE) && axi_sub_if.aw_valid;
  assign w_w_hs  = (r_wst == W_DATA) && axi_sub_if.w_valid;
  assign w_ar_hs = (r_rst == R_IDLE) && axi_sub_if.ar_valid;
  assign w_r_hs  = (r_rst == R_DATA) && axi_sub_if.r_ready;

  axi4_sub_addr_gen #(
    .ADDR_W(AXI4_ADDR_WIDTH), .DATA_W(AXI4_DATA_WIDTH),
    .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)
  ) u_wgen (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .i_load(w_aw_hs), .i_addr(axi_sub_if.aw_addr), .i_len(axi_sub_if.aw_len),
    .i_burst(axi_sub_if.aw_burst), .i_size(axi_sub_if.aw_size),
    .i_advance(w_w_hs),
    .o_idx(w_widx), .o_in_range(w_win), .o_last(w_wlast), .o_bad(w_wbad)
  );

  axi4_sub_addr_gen #(
    .ADDR_W(AXI4_ADDR_WIDTH), .DATA_W(AXI4_DATA_WIDTH),
    .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)
  ) u_rgen (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .i_load(w_ar_hs), .i_addr(axi_sub_if.ar_addr), .i_len(axi_sub_if.ar_len),
    .i_burst(axi_sub_if.ar_burst), .i_size(axi_sub_if.ar_size),
    .i_advance(w_r_hs),
    .o_idx(w_ridx), .o_in_range(w_rin), .o_last(w_rlast), .o_bad(w_rbad)
  );

  assign w_wok = !w_wbad && w_win;
  assign w_rok = !w_rbad && w_rin;

  // Write engine: accept AW, sink the counted beats, then hold B until taken.
  // Any bad beat or a w_last that disagrees with the beat count poisons B.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wst  <= W_IDLE;
      r_bid  <= '0;
      r_berr <= 1'b0;
    end else begin
      case (r_wst)
        W_IDLE: if (w_aw_hs) begin
          r_wst  <= W_DATA;
          r_bid  <= axi_sub_if.aw_id;
          r_berr <= 1'b0;
        end
        W_DATA: if (w_w_hs) begin
          if (!w_wok || (axi_sub_if.w_last != w_wlast)) r_berr <= 1'b1;
          if (w_wlast) r_wst <= B_RESP;
        end
        B_RESP: if (axi_sub_if.b_ready) r_wst <= W_IDLE;
        default: r_wst <= W_IDLE;
      endcase
    end
  end

  // Read engine: accept AR, present beats until the last one is taken.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rst <= R_IDLE;
      r_rid <= '0;
    end else begin
      case (r_rst)
        R_IDLE: if (w_ar_hs) begin
          r_rst <= R_DATA;
          r_rid <= axi_sub_if.ar_id;
        end
        R_DATA: if (w_r_hs && w_rlast) r_rst <= R_IDLE;
        default: r_rst <= R_IDLE;
      endcase
    end
  end

  // Byte-strobed array update for accepted, legal, in-range write beats.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_w_hs && w_wok) begin
      for (int b = 0; b < STRB_W; b++)
        if (axi_sub_if.w_strb[b]) r_mem[w_widx][8*b +: 8] <= axi_sub_if.w_data[8*b +: 8];
    end
  end

  assign axi_sub_if.aw_ready = (r_wst == W_IDLE);
  assign axi_sub_if.w_ready  = (r_wst == W_DATA);
  assign axi_sub_if.b_valid  = (r_wst == B_RESP);
  assign axi_sub_if.b_id     = r_bid;
  assign axi_sub_if.b_resp   = r_berr ? RESP_SLVERR : RESP_OKAY;
  assign axi_sub_if.b_user   = '0;

  assign axi_sub_if.ar_ready = (r_rst == R_IDLE);
  assign axi_sub_if.r_valid  = (r_rst == R_DATA);
  assign axi_sub_if.r_id     = r_rid;
  assign axi_sub_if.r_data   = ((r_rst == R_DATA) && w_rok) ? r_mem[w_ridx] : '0;
  assign axi_sub_if.r_resp   = ((r_rst == R_DATA) && !w_rok) ? RESP_SLVERR : RESP_OKAY;
  assign axi_sub_if.r_last   = (r_rst == R_DATA) && w_rlast;
  assign axi_sub_if.r_user   = '0;

endmodule
